fetch_unit: RTL and testbench

//   Instruction fetch stage feeding the CPU decode/control stage. Drives the instruction memory
//   and buffers returned 8-bit instructions, each with its PC, in a small prefetch queue.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/fetch_queue.sv | 72 +++++++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants and types for the CPU front end: address and
//                instruction widths, default reset PC, fetch FSM encoding and
//                the prefetch-queue entry layout.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int               ADDR_W      = 8;
    localparam int               INSTR_W     = 8;
    localparam logic [ADDR_W-1:0] RESET_PC   = 8'h00;
    localparam int               FETCH_DEPTH = 2;

    // Fetch FSM: FLUSH lasts one cycle after every redirect.
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } fetch_state_t;

    // One prefetch-queue slot: instruction together with the PC it came from.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Synchronous FIFO of DEPTH fetch entries. Clear wins over a
//                simultaneous push; pop of an empty queue is ignored.
//  Ports       : clk, rst_n      clock, async active-low reset
//                i_push/i_entry  write one entry
//                i_pop           remove head entry
//                i_clear         drop all entries
//                o_head          head entry (storage slot at read pointer)
//                o_count         number of valid entries (0..DEPTH)
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  fetch_entry_t             i_entry,
    input  logic                     i_pop,
    input  logic                     i_clear,
    output fetch_entry_t             o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);

    fetch_entry_t         r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w:0]     r_count;
    logic                 w_do_pop;
    logic                 w_do_push;

    // The fetch issue rule never lets a push land on a full queue, so push
    // needs no full guard here.
    assign w_do_pop  = i_pop && (r_count != '0) && !i_clear;
    assign w_do_push = i_push && !i_clear;

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_entry;
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= r_count + (c_ptr_w+1)'(w_do_push) - (c_ptr_w+1)'(w_do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Issues one-cycle-latency reads to
//                instruction memory, buffers {pc, instr} in a prefetch queue
//                and hands them to decode over valid/ready. A redirect flushes
//                the queue and any in-flight read, then restarts at the target.
//  Ports       : clk, rst_n               clock, async active-low reset
//                imem_req/imem_addr       memory read request and address
//                imem_data                read data, one cycle after request
//                instr/instr_pc           head instruction and its PC
//                instr_valid/instr_ready  downstream handshake
//                redirect/redirect_pc     taken branch/jump and its target
//                halt                     stop issuing (queue still drains)
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                DEPTH    = FETCH_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_data,
    output logic [INSTR_W-1:0]  instr,
    output logic [ADDR_W-1:0]   instr_pc,
    output logic                instr_valid,
    input  logic                instr_ready,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    input  logic                halt
);

    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    fetch_state_t         r_state;
    logic [ADDR_W-1:0]    r_fetch_pc;
    logic [ADDR_W-1:0]    r_issued_pc;
    logic                 r_inflight;

    logic [c_cnt_w-1:0]   w_count;
    logic [c_cnt_w:0]     w_occupancy;
    fetch_entry_t         w_head;
    fetch_entry_t         w_push_entry;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_issue;

    // Queue is always empty in FLUSH; the state term keeps valid low there
    // regardless.
    assign instr_valid = (w_count != '0) && (r_state == ST_RUN);

    // A pop during a redirect cycle is ignored: the entry is being flushed.
    assign w_pop = instr_valid && instr_ready && !redirect;

    // Slots committed after this cycle: queued entries, minus this pop, plus
    // the response still on its way. A new issue needs one free slot.
    assign w_occupancy = {1'b0, w_count} + (c_cnt_w+1)'(r_inflight)
                         - (c_cnt_w+1)'(w_pop);
    assign w_issue     = !halt && !redirect && (w_occupancy < (c_cnt_w+1)'(DEPTH));

    // Responses arriving in FLUSH belong to the pre-redirect stream.
    assign w_push       = (r_state == ST_RUN) && r_inflight;
    assign w_push_entry = {r_issued_pc, imem_data};

    // Reset gates the request so the memory sees nothing while held in reset.
    assign imem_req  = w_issue && rst_n;
    assign imem_addr = imem_req ? r_fetch_pc : '0;
    assign instr     = w_head.instr;
    assign instr_pc  = w_head.pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_fetch_pc  <= RESET_PC;
            r_issued_pc <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_issued_pc <= r_fetch_pc;
                r_fetch_pc  <= r_fetch_pc + ADDR_W'(1);
            end
            if (redirect) begin
                r_fetch_pc <= redirect_pc;
                r_state    <= ST_FLUSH;
            end else begin
                r_state    <= ST_RUN;
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .i_clear (redirect),
        .o_head  (w_head),
        .o_count (w_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit. A transaction-level model
//                tracks requested PCs with their issue cycle; an entry becomes
//                visible two cycles after issue, is consumed on valid&ready,
//                and the whole list is dropped on redirect or reset. Memory
//                returns addr^8'hA5. A second instance with RESET_PC=8'hFE
//                checks PC wrap-around after reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int c_depth = 2;

    logic       clk;
    logic       rst_n;
    logic       instr_ready;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic       halt;

    logic       imem_req, instr_valid;
    logic [7:0] imem_addr, imem_data, instr, instr_pc;
    logic       fe_req, fe_valid;
    logic [7:0] fe_addr, fe_data, fe_instr, fe_pc;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [7:0] pc;
        int         issued;
    } txn_t;

    txn_t       q[$];
    logic [7:0] exp_fetch;
    int         cyc;

    fetch_unit #(.DEPTH(c_depth), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_data(imem_data),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt)
    );

    fetch_unit #(.DEPTH(c_depth), .RESET_PC(8'hFE)) dut_fe (
        .clk(clk), .rst_n(rst_n),
        .imem_req(fe_req), .imem_addr(fe_addr), .imem_data(fe_data),
        .instr(fe_instr), .instr_pc(fe_pc), .instr_valid(fe_valid),
        .instr_ready(instr_ready), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: one-cycle read latency, noise when not requested.
    always @(posedge clk) begin
        imem_data <= imem_req ? (imem_addr ^ 8'hA5) : 8'($urandom);
        fe_data   <= fe_req   ? (fe_addr   ^ 8'hA5) : 8'($urandom);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, expv, $time);
    endtask

    // Async reset asserted mid-cycle; outputs must drop immediately. Release
    // lands just after a posedge so the next sample point is cycle 0.
    task automatic apply_reset(input int hold);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_imem_req",    32'(imem_req),    32'h0);
        check("rst_imem_addr",   32'(imem_addr),   32'h0);
        check("rst_instr",       32'(instr),       32'h0);
        check("rst_instr_pc",    32'(instr_pc),    32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'h0);
        check("rst_fe_valid",    32'(fe_valid),    32'h0);
        check("rst_fe_req",      32'(fe_req),      32'h0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            halt = ~halt;
        end
        halt = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        q.delete();
        exp_fetch = 8'h00;
        cyc       = 0;
    endtask

    // One cycle: drive inputs at negedge, check outputs 1 time unit later
    // against the transaction model, then advance the model past the posedge.
    task automatic tick(input logic rdy, input logic hlt, input logic rd, input logic [7:0] rpc);
        logic exp_valid;
        logic exp_req;
        logic pop;
        @(negedge clk);
        instr_ready = rdy;
        halt        = hlt;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
        exp_valid = 1'b0;
        if (q.size() > 0) exp_valid = (cyc - q[0].issued) >= 2;
        check("instr_valid", 32'(instr_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("instr_pc", 32'(instr_pc), 32'(q[0].pc));
            check("instr",    32'(instr),    32'(q[0].pc ^ 8'hA5));
        end
        pop = exp_valid && rdy && !rd;
        if (pop) void'(q.pop_front());
        exp_req = !hlt && !rd && (q.size() < c_depth);
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) begin
            check("imem_addr", 32'(imem_addr), 32'(exp_fetch));
            q.push_back('{pc: exp_fetch, issued: cyc});
            exp_fetch = exp_fetch + 8'd1;
        end
        if (rd) begin
            q.delete();
            exp_fetch = rpc;
        end
        cyc++;
    endtask

    initial begin
        logic [7:0] e_pc;
        rst_n       = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        halt        = 1'b0;
        q.delete();
        exp_fetch   = 8'h00;
        cyc         = 0;

        // Scenario 1 + 5: streaming from reset, both reset PCs.
        apply_reset(2);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0, 1'b0, 8'h00);
            if (i == 0) begin
                check("fe_first_req",  32'(fe_req),  32'h1);
                check("fe_first_addr", 32'(fe_addr), 32'hFE);
            end
            if (i >= 2 && i < 6) begin
                e_pc = 8'hFE + 8'(i - 2);
                check("fe_valid", 32'(fe_valid), 32'h1);
                check("fe_pc",    32'(fe_pc),    32'(e_pc));
                check("fe_instr", 32'(fe_instr), 32'(e_pc ^ 8'hA5));
            end
        end

        // Scenario 2: backpressure fills the queue, then drain.
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b0, 8'h00);
        check("full_req_low",   32'(imem_req),    32'h0);
        check("full_valid",     32'(instr_valid), 32'h1);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 1'b0, 8'h00);

        // Scenario 3: redirect with a full queue.
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 1'b1, 8'h40);
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        check("redir_t1_valid", 32'(instr_valid), 32'h0);
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        check("redir_t2_valid", 32'(instr_valid), 32'h0);
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        check("redir_t3_valid", 32'(instr_valid), 32'h1);
        check("redir_t3_pc",    32'(instr_pc),    32'h40);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 8'h00);

        // Scenario 4: back-to-back redirects, newer target wins.
        tick(1'b1, 1'b0, 1'b1, 8'h10);
        tick(1'b1, 1'b0, 1'b1, 8'h20);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 8'h00);
        check("b2b_pc", 32'(instr_pc), 32'h20);
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 8'h00);

        // Halt mid-stream, then resume.
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 1'b0, 8'h00);

        // Randomized traffic with a mid-run asynchronous reset (scenario 6).
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                apply_reset(3);
                for (int k = 0; k < 4; k++) tick(1'b1, 1'b0, 1'b0, 8'h00);
            end
            tick(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 5)  ? 1'b1 : 1'b0,
                 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
